// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the byte width and an index-width helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter / status bundle around the UART transmit arbiter.
// req_lock exists only when TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
`ifdef TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]             req_lock;
`endif
    logic [UART_DATA_W-1:0]         tx_data_in;
    logic                           tx_wr_en;
    logic                           tx_busy;
    logic [ID_W-1:0]                grant_id;
    logic                           arb_busy;
    logic                           err_timeout;

    modport master (
        input  req_valid, req_data, tx_busy,
`ifdef TX_ARB_LOCK_EN
        input  req_lock,
`endif
        output req_ready, tx_data_in, tx_wr_en, grant_id, arb_busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_busy,
`ifdef TX_ARB_LOCK_EN
        output req_lock,
`endif
        input  req_ready, tx_data_in, tx_wr_en, grant_id, arb_busy, err_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of (valid & mask) searching
// upward from last+1 with wrap-around; returns one-hot grant and its index.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = idx_w(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] last_i,
    input  logic [N-1:0]    mask_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    logic [N-1:0] cand;

    assign cand = valid_i & mask_i;

    // Scan farthest-first so the nearest candidate after last_i overwrites.
    always_comb begin
        int pos;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        for (int off = N; off >= 1; off--) begin
            pos = (int'(last_i) + off) % N;
            if (cand[pos]) begin
                grant_o      = '0;
                grant_o[pos] = 1'b1;
                idx_o        = ID_W'(pos);
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter among NUM_REQ byte sources.
// Optional frame lock per requester is compiled in with TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    uart_tx_arbiter_if.master  bus
);

    localparam int ID_W  = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    tx_arb_state_e          state_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic                   tx_wr_en_q;
    logic [ID_W-1:0]        grant_id_q;
    logic [ID_W-1:0]        last_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [NUM_REQ-1:0]     onehot_gid;
    logic [NUM_REQ-1:0]     pick_mask;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_any;
    logic                   arb_open;
    logic                   lock_active;
    logic [UART_DATA_W-1:0] pick_byte;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gid_onehot
        assign onehot_gid[gi] = (grant_id_q == ID_W'(gi));
    end

`ifdef TX_ARB_LOCK_EN
    logic lock_q;
    // A held lock restricts arbitration to the previous winner only.
    assign lock_active = lock_q && bus.req_lock[grant_id_q];
`else
    assign lock_active = 1'b0;
`endif

    assign pick_mask = lock_active ? onehot_gid : '1;

    uart_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .mask_i  (pick_mask),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign arb_open      = (state_q == IDLE) && !bus.tx_busy;
    assign bus.req_ready = arb_open ? pick_grant : '0;
    assign pick_byte     = bus.req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_wr_en_q <= 1'b1;
            grant_id_q <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef TX_ARB_LOCK_EN
                    if (lock_q && !bus.req_lock[grant_id_q]) lock_q <= 1'b0;
`endif
                    if (arb_open && pick_any) begin
                        tx_data_q  <= pick_byte;
                        grant_id_q <= pick_idx;
                        if (!lock_active) last_q <= pick_idx;
                        tx_wr_en_q <= 1'b0;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_wr_en_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never answered: the accepted byte is lost.
                        err_q   <= 1'b1;
                        state_q <= IDLE;
`ifdef TX_ARB_LOCK_EN
                        lock_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state_q <= IDLE;
`ifdef TX_ARB_LOCK_EN
                        lock_q  <= bus.req_lock[grant_id_q];
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_data_in  = tx_data_q;
    assign bus.tx_wr_en    = tx_wr_en_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.arb_busy    = (state_q != IDLE);
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter driving a behavioural 8N1 transmitter
// (bit enable every 4 clocks). Lock scenario runs only with TX_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_50m = ~clk_50m;

    // ---------------- transmitter model (never reset) ----------------
    logic       model_en   = 1'b1;
    logic       force_busy = 1'b0;
    logic       model_busy = 1'b0;
    logic       tx_line    = 1'b1;
    logic [9:0] shreg      = '0;
    logic [9:0] frame      = '0;
    int         nbits      = 0;
    int         div        = 0;
    logic [9:0] frames_q[$];
    logic [1:0] grants_q[$];

    assign bus.tx_busy = force_busy | model_busy;

    always @(posedge clk_50m) begin
        div <= (div == 3) ? 0 : div + 1;
        if (!model_busy) begin
            if (model_en && !bus.tx_wr_en) begin
                shreg      <= {1'b1, bus.tx_data_in, 1'b0};
                model_busy <= 1'b1;
                nbits      <= 0;
                grants_q.push_back(bus.grant_id);
            end
        end else if (div == 3) begin
            if (nbits == 10) begin
                model_busy <= 1'b0;
                tx_line    <= 1'b1;
                frames_q.push_back(frame);
            end else begin
                tx_line      <= shreg[0];
                frame[nbits] <= shreg[0];
                shreg        <= shreg >> 1;
                nbits        <= nbits + 1;
            end
        end
    end

    // ---------------- requester side ----------------
    logic [7:0] src_q [N][$];
    int lock_left [N];
    int rdy_cycles [N];
    int strobes, wr_run, bad_width, bad_lat, bad_strobe;
    logic hs_prev = 1'b0;
    int checks = 0;
    int passed = 0;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]     = (src_q[i].size() > 0);
            bus.req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) rdy_cycles[i] = 0;
        strobes = 0; wr_run = 0; bad_width = 0; bad_lat = 0; bad_strobe = 0;
        frames_q.delete();
        grants_q.delete();
    endtask

    // One clock: sample at negedge, apply handshakes after the posedge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk_50m);
        hs = bus.req_valid & bus.req_ready;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) rdy_cycles[i]++;
        if (!bus.tx_wr_en) begin
            wr_run++;
            if (wr_run == 1) begin
                strobes++;
                if (!hs_prev) bad_lat++;
            end
            if (wr_run == 2) bad_width++;
            if (bus.tx_busy) bad_strobe++;
        end else begin
            wr_run = 0;
        end
        hs_prev = |hs;
        @(posedge clk_50m);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(src_q[i].pop_front());
                if (lock_left[i] > 0) begin
                    lock_left[i]--;
`ifdef TX_ARB_LOCK_EN
                    if (lock_left[i] == 0) bus.req_lock[i] = 1'b0;
`endif
                end
            end
        end
        refresh();
    endtask

    task automatic run(input int n_frames, input int max_cycles, output bit done);
        bit empty;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            step();
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) empty = 1'b0;
            if (frames_q.size() >= n_frames && empty && !bus.tx_busy && !bus.arb_busy)
                done = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < N; i++) lock_left[i] = 0;
`ifdef TX_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        force_busy = 1'b1;
        refresh();
        clear_stats();
        #2 rst_n = 1'b0;
        #3;
        checks++; if (bus.tx_wr_en !== 1'b1) $display("FAIL reset_wr_en got %b want 1", bus.tx_wr_en); else passed++;
        checks++; if (bus.tx_data_in !== 8'h00) $display("FAIL reset_data got %h want 00", bus.tx_data_in); else passed++;
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else passed++;
        checks++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", bus.grant_id); else passed++;
        checks++; if (bus.err_timeout !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_timeout); else passed++;
        checks++; if (bus.arb_busy !== 1'b0) $display("FAIL reset_arb_busy got %b want 0", bus.arb_busy); else passed++;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        // busy high out of reset with a pending byte: must be held off
        src_q[0].push_back(8'h5A);
        refresh();
        repeat (6) step();
        checks++; if (rdy_cycles[0] !== 0) $display("FAIL busy_hold_ready got %0d cycles want 0", rdy_cycles[0]); else passed++;
        checks++; if (bus.arb_busy !== 1'b0) $display("FAIL busy_hold_arb got %b want 0", bus.arb_busy); else passed++;
        // withdrawn before ready: no transfer, no pointer move
        src_q[0].delete();
        refresh();
        force_busy = 1'b0;
        repeat (6) step();
        checks++; if (strobes !== 0 || frames_q.size() !== 0) $display("FAIL withdrawn_no_launch got strobes=%0d frames=%0d want 0/0", strobes, frames_q.size()); else passed++;
        checks++; if (bus.err_timeout !== 1'b0) $display("FAIL busy_hold_err got %b want 0", bus.err_timeout); else passed++;
        $display("reset: done");
    endtask

    task automatic test_contention();
        logic [7:0] exp_b [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [9:0] want;
        bit done;
        clear_stats();
        src_q[0].push_back(8'h10); src_q[0].push_back(8'h14);
        src_q[1].push_back(8'h11);
        src_q[2].push_back(8'h12);
        src_q[3].push_back(8'h13);
        refresh();
        run(5, 800, done);
        checks++; if (done !== 1'b1) $display("FAIL contention_timeout got frames=%0d want 5", frames_q.size()); else passed++;
        for (int k = 0; k < 5; k++) begin
            want = {1'b1, exp_b[k], 1'b0};
            checks++;
            if (k >= frames_q.size()) $display("FAIL contention_frame%0d got none want %h", k, want);
            else if (frames_q[k] !== want) $display("FAIL contention_frame%0d got %h want %h", k, frames_q[k], want);
            else passed++;
            checks++;
            if (k >= grants_q.size()) $display("FAIL contention_grant%0d got none want %0d", k, exp_g[k]);
            else if (grants_q[k] !== exp_g[k]) $display("FAIL contention_grant%0d got %0d want %0d", k, grants_q[k], exp_g[k]);
            else passed++;
            $display("contention: byte %0d frame %h grant %0d", k,
                     (k < frames_q.size()) ? frames_q[k] : 10'h0, (k < grants_q.size()) ? grants_q[k] : 2'd0);
        end
        checks++; if (bad_width !== 0 || bad_lat !== 0) $display("FAIL contention_strobe got width_err=%0d lat_err=%0d want 0/0", bad_width, bad_lat); else passed++;
    endtask

    task automatic test_single();
        bit done;
        clear_stats();
        src_q[0].push_back(8'hA5);
        refresh();
        run(1, 200, done);
        checks++; if (done !== 1'b1) $display("FAIL single_timeout got frames=%0d want 1", frames_q.size()); else passed++;
        checks++;
        if (frames_q.size() != 1) $display("FAIL single_frame got %0d frames want 1", frames_q.size());
        else if (frames_q[0] !== {1'b1, 8'hA5, 1'b0}) $display("FAIL single_frame got %h want %h", frames_q[0], {1'b1, 8'hA5, 1'b0});
        else passed++;
        checks++; if (rdy_cycles[0] !== 1) $display("FAIL single_ready got %0d cycles want 1", rdy_cycles[0]); else passed++;
        checks++; if (strobes !== 1 || bad_width !== 0) $display("FAIL single_strobe got strobes=%0d width_err=%0d want 1/0", strobes, bad_width); else passed++;
        checks++; if (bad_lat !== 0) $display("FAIL single_latency got %0d strobes not following accept want 0", bad_lat); else passed++;
        checks++; if (bus.grant_id !== 2'd0) $display("FAIL single_grant got %0d want 0", bus.grant_id); else passed++;
        $display("single: byte A5 ready_cycles %0d strobes %0d", rdy_cycles[0], strobes);
    endtask

    task automatic test_backpressure();
        bit done;
        clear_stats();
        force_busy = 1'b1;
        src_q[1].push_back(8'h55);
        src_q[2].push_back(8'h99);
        refresh();
        repeat (8) step();
        checks++; if (rdy_cycles[1] !== 0 || rdy_cycles[2] !== 0) $display("FAIL bp_ready_while_busy got r1=%0d r2=%0d want 0/0", rdy_cycles[1], rdy_cycles[2]); else passed++;
        src_q[2].delete();
        refresh();
        force_busy = 1'b0;
        run(1, 200, done);
        repeat (50) step();
        checks++;
        if (frames_q.size() != 1) $display("FAIL bp_frames got %0d frames want 1", frames_q.size());
        else if (frames_q[0] !== {1'b1, 8'h55, 1'b0}) $display("FAIL bp_frames got %h want %h", frames_q[0], {1'b1, 8'h55, 1'b0});
        else passed++;
        checks++; if (rdy_cycles[1] !== 1) $display("FAIL bp_ready_once got %0d cycles want 1", rdy_cycles[1]); else passed++;
        checks++;
        if (grants_q.size() != 1) $display("FAIL bp_grant got %0d launches want 1", grants_q.size());
        else if (grants_q[0] !== 2'd1) $display("FAIL bp_grant got %0d want 1", grants_q[0]);
        else passed++;
        $display("backpressure: frames %0d ready1 cycles %0d", frames_q.size(), rdy_cycles[1]);
    endtask

    task automatic test_timeout();
        int t;
        bit done;
        clear_stats();
        model_en = 1'b0;
        src_q[0].push_back(8'hE1);
        refresh();
        for (int c = 0; c < 20 && strobes == 0; c++) step();
        t = 0;
        for (int c = 0; c < 40 && bus.err_timeout !== 1'b1; c++) begin
            step();
            t++;
        end
        // err rises on the 15th edge after the one that ends LAUNCH
        checks++; if (t !== 15) $display("FAIL timeout_delay got %0d cycles want 15", t); else passed++;
        checks++; if (bus.arb_busy !== 1'b0) $display("FAIL timeout_idle got arb_busy=%b want 0", bus.arb_busy); else passed++;
        $display("timeout: err_timeout after %0d cycles", t);
        model_en = 1'b1;
        src_q[2].push_back(8'h62);
        refresh();
        run(1, 200, done);
        checks++;
        if (frames_q.size() != 1) $display("FAIL timeout_recover got %0d frames want 1", frames_q.size());
        else if (frames_q[0] !== {1'b1, 8'h62, 1'b0}) $display("FAIL timeout_recover got %h want %h", frames_q[0], {1'b1, 8'h62, 1'b0});
        else passed++;
        checks++; if (bus.err_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", bus.err_timeout); else passed++;
    endtask

    task automatic test_reset_mid();
        bit done;
        clear_stats();
        src_q[1].push_back(8'h3C);
        refresh();
        for (int c = 0; c < 100 && !(model_busy && nbits >= 3); c++) step();
        src_q[3].push_back(8'h77);
        refresh();
        rst_n = 1'b0;
        #2;
        checks++; if (bus.tx_wr_en !== 1'b1 || bus.tx_data_in !== 8'h00 || bus.grant_id !== 2'd0)
            $display("FAIL midreset_outputs got wr=%b data=%h gid=%0d want 1/00/0", bus.tx_wr_en, bus.tx_data_in, bus.grant_id); else passed++;
        checks++; if (bus.err_timeout !== 1'b0 || bus.req_ready !== 4'b0000)
            $display("FAIL midreset_status got err=%b ready=%b want 0/0000", bus.err_timeout, bus.req_ready); else passed++;
        checks++; if (bus.tx_busy !== 1'b1) $display("FAIL midreset_tx_running got %b want 1", bus.tx_busy); else passed++;
        repeat (2) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        strobes = 0;
        run(2, 300, done);
        checks++; if (bad_strobe !== 0) $display("FAIL midreset_strobe_while_busy got %0d want 0", bad_strobe); else passed++;
        checks++;
        if (frames_q.size() != 2) $display("FAIL midreset_frames got %0d frames want 2", frames_q.size());
        else if (frames_q[0] !== {1'b1, 8'h3C, 1'b0} || frames_q[1] !== {1'b1, 8'h77, 1'b0})
            $display("FAIL midreset_frames got %h,%h want %h,%h", frames_q[0], frames_q[1], {1'b1, 8'h3C, 1'b0}, {1'b1, 8'h77, 1'b0});
        else passed++;
        checks++; if (strobes !== 1) $display("FAIL midreset_relaunch got %0d strobes want 1", strobes); else passed++;
        $display("reset_mid: frames %0d strobes after reset %0d", frames_q.size(), strobes);
    endtask

`ifdef TX_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] exp_b [4] = '{8'h21, 8'h22, 8'h23, 8'h40};
        logic [1:0] exp_g [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        bit done;
        clear_stats();
        bus.req_lock[2] = 1'b1;
        lock_left[2] = 3;
        src_q[2].push_back(8'h21); src_q[2].push_back(8'h22); src_q[2].push_back(8'h23);
        refresh();
        for (int c = 0; c < 50 && src_q[2].size() == 3; c++) step();
        src_q[0].push_back(8'h40);
        refresh();
        run(4, 600, done);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= frames_q.size()) $display("FAIL lock_frame%0d got none want %h", k, exp_b[k]);
            else if (frames_q[k] !== {1'b1, exp_b[k], 1'b0}) $display("FAIL lock_frame%0d got %h want %h", k, frames_q[k], {1'b1, exp_b[k], 1'b0});
            else passed++;
            checks++;
            if (k >= grants_q.size()) $display("FAIL lock_grant%0d got none want %0d", k, exp_g[k]);
            else if (grants_q[k] !== exp_g[k]) $display("FAIL lock_grant%0d got %0d want %0d", k, grants_q[k], exp_g[k]);
            else passed++;
            $display("lock: byte %0d done", k);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_timeout();
        test_reset_mid();
`ifdef TX_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
